// File: rtl/csr_seq.sv
`default_nettype none
// ============================================================================
// Module   : csr_seq
// Desc     : Sequences CSR read-modify-write ops, ecall trap entry and mret
//            return against an external CSR file with a combinational read port.
// Revision : 1.0
// ============================================================================
module csr_seq #(
    parameter logic [11:0] MTVEC_ADDR   = 12'h305,
    parameter logic [11:0] MEPC_ADDR    = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR  = 12'h342,
    parameter logic [11:0] MSTATUS_ADDR = 12'h300
) (
    input  logic        I_clk,
    input  logic        I_rst,
    input  logic        I_req_valid,
    output logic        O_req_ready,
    input  logic [1:0]  I_req_op,
    input  logic [11:0] I_csr_addr,
    input  logic [31:0] I_csr_src,
    input  logic [1:0]  I_csr_ctrl,
    input  logic [31:0] I_pc,
    output logic [11:0] O_csr_raddr,
    input  logic [31:0] I_csr_rdata,
    output logic        O_csr_we,
    output logic [11:0] O_csr_waddr,
    output logic [31:0] O_csr_wdata,
    output logic        O_rd_valid,
    output logic [31:0] O_rd_data,
    output logic        O_redirect,
    output logic [31:0] O_redirect_pc,
    output logic        O_busy
);

    localparam logic [1:0]  c_OP_CSR      = 2'b00;
    localparam logic [1:0]  c_OP_ECALL    = 2'b01;
    localparam logic [1:0]  c_OP_MRET     = 2'b10;
    localparam logic [1:0]  c_CTRL_NOP    = 2'b00;
    localparam logic [1:0]  c_CTRL_WRITE  = 2'b01;
    localparam logic [1:0]  c_CTRL_SET    = 2'b10;
    localparam logic [1:0]  c_CTRL_CLEAR  = 2'b11;
    localparam logic [31:0] c_CAUSE_ECALL = 32'd11;
    localparam logic [31:0] c_ALIGN_MASK  = ~32'd3;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RW      = 3'd1,
        S_T_EPC   = 3'd2,
        S_T_CAUSE = 3'd3,
        S_T_STAT  = 3'd4,
        S_T_JMP   = 3'd5,
        S_R_STAT  = 3'd6,
        S_R_JMP   = 3'd7
    } state_t;

    // The accepted op is captured by the state the FSM branches into.
    state_t      state_q;
    logic [11:0] addr_q;
    logic [31:0] src_q;
    logic [1:0]  ctrl_q;
    logic [31:0] pc_q;

    logic        w_rw_we;
    logic [31:0] w_rw_wdata;
    logic [31:0] w_stat_trap;
    logic [31:0] w_stat_ret;

    always_ff @(posedge I_clk) begin
        if (I_rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            src_q   <= '0;
            ctrl_q  <= '0;
            pc_q    <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (I_req_valid) begin
                        addr_q <= I_csr_addr;
                        src_q  <= I_csr_src;
                        ctrl_q <= I_csr_ctrl;
                        pc_q   <= I_pc;
                        case (I_req_op)
                            c_OP_CSR:   state_q <= S_RW;
                            c_OP_ECALL: state_q <= S_T_EPC;
                            c_OP_MRET:  state_q <= S_R_STAT;
                            default:    state_q <= S_IDLE;
                        endcase
                    end
                end
                S_RW:      state_q <= S_IDLE;
                S_T_EPC:   state_q <= S_T_CAUSE;
                S_T_CAUSE: state_q <= S_T_STAT;
                S_T_STAT:  state_q <= S_T_JMP;
                S_T_JMP:   state_q <= S_IDLE;
                S_R_STAT:  state_q <= S_R_JMP;
                S_R_JMP:   state_q <= S_IDLE;
                default:   state_q <= S_IDLE;
            endcase
        end
    end

    // Set/clear with a zero mask leave the CSR untouched, so no write is issued.
    assign w_rw_we = (ctrl_q == c_CTRL_WRITE) ||
                     ((ctrl_q != c_CTRL_NOP) && (src_q != '0));

    always_comb begin
        case (ctrl_q)
            c_CTRL_WRITE: w_rw_wdata = src_q;
            c_CTRL_SET:   w_rw_wdata = I_csr_rdata | src_q;
            c_CTRL_CLEAR: w_rw_wdata = I_csr_rdata & ~src_q;
            default:      w_rw_wdata = I_csr_rdata;
        endcase
    end

    always_comb begin
        w_stat_trap        = I_csr_rdata;
        w_stat_trap[7]     = I_csr_rdata[3];
        w_stat_trap[3]     = 1'b0;
        w_stat_trap[12:11] = 2'b11;
        w_stat_ret         = I_csr_rdata;
        w_stat_ret[3]      = I_csr_rdata[7];
        w_stat_ret[7]      = 1'b1;
        w_stat_ret[12:11]  = 2'b11;
    end

    always_comb begin
        O_req_ready   = 1'b0;
        O_busy        = 1'b0;
        O_csr_raddr   = '0;
        O_csr_we      = 1'b0;
        O_csr_waddr   = '0;
        O_csr_wdata   = '0;
        O_rd_valid    = 1'b0;
        O_rd_data     = '0;
        O_redirect    = 1'b0;
        O_redirect_pc = '0;
        if (!I_rst) begin
            O_req_ready = (state_q == S_IDLE);
            O_busy      = (state_q != S_IDLE);
            case (state_q)
                S_RW: begin
                    O_csr_raddr = addr_q;
                    O_rd_valid  = 1'b1;
                    O_rd_data   = I_csr_rdata;
                    if (w_rw_we) begin
                        O_csr_we    = 1'b1;
                        O_csr_waddr = addr_q;
                        O_csr_wdata = w_rw_wdata;
                    end
                end
                S_T_EPC: begin
                    O_csr_we    = 1'b1;
                    O_csr_waddr = MEPC_ADDR;
                    O_csr_wdata = pc_q & c_ALIGN_MASK;
                end
                S_T_CAUSE: begin
                    O_csr_we    = 1'b1;
                    O_csr_waddr = MCAUSE_ADDR;
                    O_csr_wdata = c_CAUSE_ECALL;
                end
                S_T_STAT: begin
                    O_csr_raddr = MSTATUS_ADDR;
                    O_csr_we    = 1'b1;
                    O_csr_waddr = MSTATUS_ADDR;
                    O_csr_wdata = w_stat_trap;
                end
                S_T_JMP: begin
                    // Only direct-mode vectoring: the MODE field is dropped.
                    O_csr_raddr   = MTVEC_ADDR;
                    O_redirect    = 1'b1;
                    O_redirect_pc = I_csr_rdata & c_ALIGN_MASK;
                end
                S_R_STAT: begin
                    O_csr_raddr = MSTATUS_ADDR;
                    O_csr_we    = 1'b1;
                    O_csr_waddr = MSTATUS_ADDR;
                    O_csr_wdata = w_stat_ret;
                end
                S_R_JMP: begin
                    O_csr_raddr   = MEPC_ADDR;
                    O_redirect    = 1'b1;
                    O_redirect_pc = I_csr_rdata;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
